// File: rtl/manycore_run_controller_pkg.sv
// Shared definitions for the many-core run controller: controller phases and
// the status encoding that the processor core also decodes.
package manycore_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RESET = 2'b01,
    ST_RUN   = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam logic [1:0] STATUS_IDLE  = 2'b00;
  localparam logic [1:0] STATUS_RESET = 2'b01;
  localparam logic [1:0] STATUS_RUN   = 2'b10;
  localparam logic [1:0] STATUS_DONE  = 2'b11;

endpackage

// File: rtl/manycore_run_controller_counter.sv
// 32-bit saturating run-cycle counter with a watchdog compare.
// expire pulses in the enabled cycle whose increment would make the count
// equal to a nonzero limit, so a run with limit L lasts exactly L cycles.
module run_cycle_counter #(
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic [31:0]          count,
  output logic                 expire
);

  // Compare width wide enough for both count+1 and the limit.
  localparam int CW = ((TIMEOUT_W > 32) ? TIMEOUT_W : 32) + 1;

  logic [31:0]   count_q, count_d;
  logic [CW-1:0] next_ext_s;
  logic [CW-1:0] limit_ext_s;

  // Next count (clear wins, saturate at all-ones) and watchdog compare.
  always_comb begin
    count_d     = count_q;
    expire      = 1'b0;
    next_ext_s  = CW'(count_q) + CW'(1);
    limit_ext_s = CW'(limit);
    if (clear) begin
      count_d = 32'd0;
    end else if (enable && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
    if (enable && (limit != '0) && (next_ext_s == limit_ext_s)) begin
      expire = 1'b1;
    end else begin
      expire = 1'b0;
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/manycore_run_controller.sv
// Run controller for an N-core machine: detects the start edge, latches the
// core subset and watchdog limit, sequences IDLE/RESET/RUN/DONE and keeps
// per-run finish and cycle statistics. All outputs come straight from flops.
module manycore_run_controller
  import manycore_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT_W  = 16
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 start_process,
  input  logic [NUM_CORES-1:0] core_mask,
  input  logic [NUM_CORES-1:0] end_process,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  output logic [NUM_CORES-1:0] core_rst,
  output logic [1:0]           status,
  output logic                 busy,
  output logic                 done,
  output logic                 timed_out,
  output logic [NUM_CORES-1:0] finished_mask,
  output logic [31:0]          cycle_count
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_e               state_q, state_d;
  logic                 start_prev_q;
  logic [RW-1:0]        rst_cnt_q, rst_cnt_d;
  logic [NUM_CORES-1:0] active_mask_q, active_mask_d;
  logic [TIMEOUT_W-1:0] limit_q, limit_d;
  logic [NUM_CORES-1:0] finished_q, finished_d;
  logic                 timed_out_q, timed_out_d;
  logic [NUM_CORES-1:0] core_rst_q, core_rst_d;
  logic [1:0]           status_q, status_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 start_edge_s;
  logic                 cnt_clear_s;
  logic                 cnt_en_s;
  logic                 expire_s;
  logic [NUM_CORES-1:0] fin_next_s;

  assign start_edge_s = start_process & ~start_prev_q;

  run_cycle_counter #(
    .TIMEOUT_W(TIMEOUT_W)
  ) u_counter (
    .clock (clock),
    .rst_n (rst_n),
    .clear (cnt_clear_s),
    .enable(cnt_en_s),
    .limit (limit_q),
    .count (cycle_count),
    .expire(expire_s)
  );

  // Next-state, run bookkeeping and the registered-output decode of the next state.
  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    active_mask_d = active_mask_q;
    limit_d       = limit_q;
    finished_d    = finished_q;
    timed_out_d   = timed_out_q;
    cnt_clear_s   = 1'b0;
    cnt_en_s      = 1'b0;
    fin_next_s    = finished_q | (end_process & active_mask_q);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_edge_s && (core_mask != '0)) begin
          active_mask_d = core_mask;
          limit_d       = timeout_limit;
          finished_d    = '0;
          timed_out_d   = 1'b0;
          cnt_clear_s   = 1'b1;
          rst_cnt_d     = RW'(RST_CYCLES - 1);
          state_d       = ST_RESET;
        end else begin
          state_d = state_q;
        end
      end
      ST_RESET: begin
        if (rst_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q - RW'(1);
        end
      end
      ST_RUN: begin
        cnt_en_s   = 1'b1;
        finished_d = fin_next_s;
        // Completion takes priority over a coincident watchdog expiry.
        if (fin_next_s == active_mask_q) begin
          timed_out_d = 1'b0;
          state_d     = ST_DONE;
        end else if (expire_s) begin
          timed_out_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    case (state_d)
      ST_RESET: begin
        core_rst_d = '1;
        status_d   = STATUS_RESET;
        busy_d     = 1'b1;
        done_d     = 1'b0;
      end
      ST_RUN: begin
        core_rst_d = ~active_mask_d;
        status_d   = STATUS_RUN;
        busy_d     = 1'b1;
        done_d     = 1'b0;
      end
      ST_DONE: begin
        core_rst_d = '1;
        status_d   = STATUS_DONE;
        busy_d     = 1'b0;
        done_d     = 1'b1;
      end
      default: begin
        core_rst_d = '1;
        status_d   = STATUS_IDLE;
        busy_d     = 1'b0;
        done_d     = 1'b0;
      end
    endcase
  end

  // State, run context and output registers; start history resets high.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      start_prev_q  <= 1'b1;
      rst_cnt_q     <= '0;
      active_mask_q <= '0;
      limit_q       <= '0;
      finished_q    <= '0;
      timed_out_q   <= 1'b0;
      core_rst_q    <= '1;
      status_q      <= STATUS_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_prev_q  <= start_process;
      rst_cnt_q     <= rst_cnt_d;
      active_mask_q <= active_mask_d;
      limit_q       <= limit_d;
      finished_q    <= finished_d;
      timed_out_q   <= timed_out_d;
      core_rst_q    <= core_rst_d;
      status_q      <= status_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign core_rst      = core_rst_q;
  assign status        = status_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign timed_out     = timed_out_q;
  assign finished_mask = finished_q;

endmodule

// File: tb/tb_manycore_run_controller.sv
// Bench for manycore_run_controller: a 4-core and an 8-core instance share
// stimulus and are compared every cycle against a phase-level reference model.
module tb_manycore_run_controller;

  localparam int P_IDLE  = 0;
  localparam int P_RESET = 1;
  localparam int P_RUN   = 2;
  localparam int P_DONE  = 3;
  localparam int RSTC    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_process;
  logic [7:0]  core_mask;
  logic [7:0]  end_process;
  logic [15:0] timeout_limit;

  logic [3:0]  core_rst4, fin4;
  logic [1:0]  status4;
  logic        busy4, done4, to4;
  logic [31:0] cnt4;
  logic [7:0]  core_rst8, fin8;
  logic [1:0]  status8;
  logic        busy8, done8, to8;
  logic [31:0] cnt8;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model state, index 0 = 4-core, 1 = 8-core.
  int          m_phase[2];
  int          m_left[2];
  bit          m_prev[2];
  bit          m_to[2];
  logic [31:0] m_act[2];
  logic [31:0] m_fin[2];
  longint      m_cnt[2];
  int          m_lim[2];

  always #5 clk = ~clk;

  manycore_run_controller #(.NUM_CORES(4), .RST_CYCLES(RSTC), .TIMEOUT_W(16)) dut4 (
    .clock(clk), .rst_n(rst_n), .start_process(start_process),
    .core_mask(core_mask[3:0]), .end_process(end_process[3:0]),
    .timeout_limit(timeout_limit), .core_rst(core_rst4), .status(status4),
    .busy(busy4), .done(done4), .timed_out(to4), .finished_mask(fin4),
    .cycle_count(cnt4));

  manycore_run_controller #(.NUM_CORES(8), .RST_CYCLES(RSTC), .TIMEOUT_W(16)) dut8 (
    .clock(clk), .rst_n(rst_n), .start_process(start_process),
    .core_mask(core_mask), .end_process(end_process),
    .timeout_limit(timeout_limit), .core_rst(core_rst8), .status(status8),
    .busy(busy8), .done(done8), .timed_out(to8), .finished_mask(fin8),
    .cycle_count(cnt8));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] nmask(int k);
    return (k == 0) ? 32'h0000_000F : 32'h0000_00FF;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = P_IDLE; m_prev[k] = 1'b1; m_to[k] = 1'b0;
      m_act[k] = 32'd0; m_fin[k] = 32'd0; m_cnt[k] = 0; m_left[k] = 0; m_lim[k] = 0;
    end
  endtask

  task automatic m_step();
    for (int k = 0; k < 2; k++) begin
      bit          edge_s, all_done, wd;
      logic [31:0] msk, endp, nf;
      msk    = {24'd0, core_mask} & nmask(k);
      endp   = {24'd0, end_process} & nmask(k);
      edge_s = start_process && !m_prev[k];
      m_prev[k] = start_process;
      case (m_phase[k])
        P_IDLE, P_DONE: begin
          if (edge_s && msk != 32'd0) begin
            m_act[k] = msk; m_lim[k] = int'(timeout_limit);
            m_fin[k] = 32'd0; m_cnt[k] = 0; m_to[k] = 1'b0;
            m_left[k] = RSTC; m_phase[k] = P_RESET;
          end
        end
        P_RESET: begin
          m_left[k]--;
          if (m_left[k] == 0) m_phase[k] = P_RUN;
        end
        P_RUN: begin
          nf       = m_fin[k] | (endp & m_act[k]);
          all_done = (nf == m_act[k]);
          wd       = (m_lim[k] != 0) && (m_cnt[k] + 1 == longint'(m_lim[k]));
          m_fin[k] = nf;
          if (m_cnt[k] < 64'hFFFF_FFFF) m_cnt[k]++;
          if (all_done) begin
            m_phase[k] = P_DONE; m_to[k] = 1'b0;
          end else if (wd) begin
            m_phase[k] = P_DONE; m_to[k] = 1'b1;
          end
        end
        default: m_phase[k] = P_IDLE;
      endcase
    end
  endtask

  function automatic logic [31:0] exp_rst(int k);
    return (m_phase[k] == P_RUN) ? (~m_act[k] & nmask(k)) : nmask(k);
  endfunction

  task automatic check_all();
    chk("d4.status", status4, m_phase[0]);
    chk("d4.core_rst", core_rst4, exp_rst(0));
    chk("d4.busy", busy4, (m_phase[0] == P_RESET || m_phase[0] == P_RUN));
    chk("d4.done", done4, (m_phase[0] == P_DONE));
    chk("d4.timed_out", to4, m_to[0]);
    chk("d4.finished", fin4, m_fin[0]);
    chk("d4.cycles", cnt4, m_cnt[0]);
    chk("d8.status", status8, m_phase[1]);
    chk("d8.core_rst", core_rst8, exp_rst(1));
    chk("d8.busy", busy8, (m_phase[1] == P_RESET || m_phase[1] == P_RUN));
    chk("d8.done", done8, (m_phase[1] == P_DONE));
    chk("d8.timed_out", to8, m_to[1]);
    chk("d8.finished", fin8, m_fin[1]);
    chk("d8.cycles", cnt8, m_cnt[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
    check_all();
  endtask

  // Called just after tick(): asserts rst_n between clock edges.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 m_reset();
    check_all();
    #1 rst_n = 1'b1;
  endtask

  task automatic start_run(input logic [7:0] msk, input logic [15:0] lim);
    start_process = 1'b0;
    end_process   = 8'h00;
    tick();
    core_mask     = msk;
    timeout_limit = lim;
    start_process = 1'b1;
    tick();
  endtask

  task automatic wait_run();
    for (int i = 0; i < 10; i++) begin
      if (m_phase[0] != P_RESET) break;
      tick();
    end
    chk("wait_run", status4, 2'd2);
  endtask

  initial begin
    int r;
    rst_n = 1'b0; start_process = 1'b0; core_mask = 8'h00;
    end_process = 8'h00; timeout_limit = 16'd0;
    m_reset();
    #12;
    check_all();
    rst_n = 1'b1;
    tick();

    // start held high through reset release is not an edge
    start_process = 1'b1;
    core_mask = 8'hFF;
    tick();
    async_reset();
    tick(); tick(); tick();
    chk("hi_at_release", status4, 2'd0);

    // scenario 1 (both sizes), start pulses in RESET and RUN ignored
    start_run(8'hFF, 16'd0);
    chk("s1.T1_status", status4, 2'd1);
    start_process = 1'b0;
    tick();
    chk("s1.T2_status", status4, 2'd1);
    start_process = 1'b1;
    tick();
    chk("s1.T3_status", status4, 2'd2);
    chk("s1.T3_core_rst", core_rst8, 8'h00);
    start_process = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (m_phase[0] != P_RUN) break;
      r = int'(m_cnt[0]);
      end_process = 8'h00;
      end_process[0] = (r >= 5);
      end_process[1] = (r >= 9);
      end_process[2] = (r >= 9);
      end_process[3] = (r >= 20);
      end_process[7:4] = (r >= 12) ? 4'hF : 4'h0;
      start_process = (r >= 3 && r < 6);
      tick();
    end
    chk("s1.status", status4, 2'd3);
    chk("s1.cycles", cnt4, 32'd21);
    chk("s1.finished", fin4, 4'hF);
    chk("s1.timed_out", to4, 1'b0);
    chk("s1.cycles8", cnt8, 32'd21);
    chk("s1.finished8", fin8, 8'hFF);

    // zero-mask start leaves state unchanged
    start_run(8'h00, 16'd0);
    tick(); tick();
    chk("mask0.status", status4, 2'd3);
    chk("mask0.finished", fin4, 4'hF);

    // mask 0101
    start_run(8'h05, 16'd0);
    wait_run();
    chk("m5.core_rst", core_rst4, 4'b1010);
    for (int i = 0; i < 60; i++) begin
      if (m_phase[0] != P_RUN) break;
      r = int'(m_cnt[0]);
      end_process = 8'h00;
      end_process[3] = (r == 1);
      end_process[0] = (r >= 3);
      end_process[2] = (r >= 6);
      tick();
    end
    chk("m5.status", status4, 2'd3);
    chk("m5.finished", fin4, 4'b0101);
    chk("m5.cycles", cnt4, 32'd7);

    // watchdog limit 10, core 3 silent, then finishing in the last cycle
    for (int pass = 0; pass < 2; pass++) begin
      start_run(8'h0F, 16'd10);
      wait_run();
      for (int i = 0; i < 60; i++) begin
        if (m_phase[0] != P_RUN) break;
        r = int'(m_cnt[0]);
        end_process = (r >= 2) ? 8'h07 : 8'h00;
        end_process[3] = (pass == 1) && (r >= 9);
        tick();
      end
      chk("wd.status", status4, 2'd3);
      chk("wd.cycles", cnt4, 32'd10);
      chk("wd.timed_out", to4, (pass == 0));
      chk("wd.finished", fin4, (pass == 0) ? 4'h7 : 4'hF);
    end

    // from DONE straight to RESET with cleared stats, mask 0011
    start_run(8'h03, 16'd0);
    chk("redo.status", status4, 2'd1);
    chk("redo.cycles", cnt4, 32'd0);
    chk("redo.finished", fin4, 4'h0);
    chk("redo.timed_out", to4, 1'b0);
    wait_run();
    end_process = 8'h03;
    tick();
    chk("redo.done", status4, 2'd3);

    // rst_n mid-run, then a fresh run
    start_run(8'h0F, 16'd0);
    wait_run();
    end_process = 8'h01;
    for (int i = 0; i < 5; i++) tick();
    async_reset();
    chk("midrst.status", status4, 2'd0);
    chk("midrst.cycles", cnt4, 32'd0);
    start_run(8'h0F, 16'd0);
    wait_run();
    end_process = 8'h0F;
    tick();
    chk("fresh.cycles", cnt4, 32'd1);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) start_process = ~start_process;
      if ($urandom_range(0, 7) == 0)
        core_mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 7) == 0)
        timeout_limit = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 30));
      if ($urandom_range(0, 24) == 0) end_process = 8'h00;
      else if ($urandom_range(0, 4) == 0) end_process[$urandom_range(0, 7)] = 1'b1;
      tick();
      if ($urandom_range(0, 299) == 0) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/manycore_run_controller.md
# manycore_run_controller

Parametrised run controller for an N-core shared-instruction-stream machine. It replaces the single-core-finish state controller: it launches a run on a selectable subset of cores and holds each core in reset around the run. Completion requires every enabled core to signal finish, and a run-cycle watchdog can abort the run. It sits between the top-level start input and the per-core reset/status inputs, in the divided core clock domain.

## Interface
- NUM_CORES, 4, number of cores controlled (1..32)
- RST_CYCLES, 2, cycles core_rst is held asserted before RUN (>=1)
- TIMEOUT_W, 16, width of the watchdog limit
- clock  in  1  core clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start_process  in  1  level from board; a rising edge requests a run
- core_mask  in  NUM_CORES  enabled cores; sampled on the accepted start edge
- end_process  in  NUM_CORES  per-core finish flag, level
- timeout_limit  in  TIMEOUT_W  max RUN cycles; 0 disables the watchdog; sampled on the accepted start edge
- core_rst  out  NUM_CORES  active-high reset to each core
- status  out  2  broadcast phase: 00 IDLE, 01 RESET, 10 RUN, 11 DONE
- busy  out  1  high in RESET and RUN
- done  out  1  high in DONE
- timed_out  out  1  high in DONE if the run ended by watchdog
- finished_mask  out  NUM_CORES  sticky per-core finish record for the current/last run
- cycle_count  out  32  RUN cycles elapsed in the current/last run

## Operation
- State machine states: IDLE, RESET, RUN, DONE. All outputs are registered.
- Start edge: start_process high and its previous-cycle sample low. Only edges seen in IDLE or DONE are accepted. Edges in RESET/RUN are ignored.
- Accepted edge with core_mask==0: ignored; the state is unchanged.
- Accepted edge with a nonzero mask:
  - latch active_mask and limit
  - clear finished_mask, cycle_count and timed_out
  - go to RESET
- RESET: core_rst is all ones. A down-counter runs RST_CYCLES cycles, then the state goes to RUN. end_process is ignored in this state.
- RUN:
  - core_rst = ~active_mask; masked-off cores stay in reset
  - finished_mask |= end_process & active_mask each cycle; finished bits never clear during the run
  - cycle_count increments each cycle and saturates at all-ones
- RUN exit on completion: (finished_mask | (end_process & active_mask)) == active_mask. The next state is DONE with timed_out=0.
- RUN exit on watchdog: limit!=0 and cycle_count+1 == limit. The next state is DONE with timed_out=1. If completion and watchdog occur in the same cycle, completion wins and timed_out=0.
- DONE: core_rst all ones. finished_mask, cycle_count and timed_out are frozen until the next accepted start edge, which goes directly to RESET.
- IDLE: core_rst all ones, status 00.
- end_process bits of masked-off cores never affect state or finished_mask.

## Timing
- Reset (rst_n low, asynchronous) forces:
  - state IDLE, core_rst all ones, status 00
  - busy 0, done 0, timed_out 0
  - finished_mask 0, cycle_count 0
  - start-edge history 1, so a start_process that is high when rst_n releases is not treated as an edge
- rst_n asserted mid-run aborts immediately to the values above.
- Start edge sampled at cycle T: status=01, busy=1 and core_rst all ones from T+1. Status goes to 10 at T+1+RST_CYCLES; the active cores' core_rst bits drop on the same edge.
- The last required end_process bit sampled high at cycle U gives status=11, done=1, busy=0 at U+1. The finished_mask bit is set at U+1.
- With watchdog limit L, RUN lasts exactly L cycles; cycle_count reads L in DONE.
- Start-to-RUN latency is 1+RST_CYCLES cycles. Finish-to-DONE latency is 1 cycle.

## Structure
- Package manycore_pkg holds:
  - state enum (IDLE, RESET, RUN, DONE)
  - the status encoding constants, shared with the processor core's status decode
- One sub-module, run_cycle_counter: 32-bit saturating counter with sync clear/enable and watchdog compare against a TIMEOUT_W limit (0 = disabled), producing an expire pulse.
- Edge detect, mask latching and the state machine live in manycore_run_controller.

## Test plan
- NUM_CORES=4, RST_CYCLES=2, mask 4'b1111, limit 0: start edge at T -> status 01 at T+1..T+2, 10 at T+3. end_process bits rise at run cycles 5, 9, 9, 20 -> DONE at run cycle 21, finished_mask 1111, cycle_count 21, timed_out 0.
- Mask 4'b0101: core_rst stays 4'b1010 in RUN. Cores 0 and 2 finishing gives DONE even though end_process[1] never rises. end_process[3] pulsing early leaves finished_mask[3]=0.
- Limit 10, core 3 never finishes: DONE after exactly 10 RUN cycles, timed_out 1, cycle_count 10, finished_mask excludes bit 3. Same run with the final finish at RUN cycle 10: timed_out 0.
- Start edge with mask 0 -> stays IDLE. Start edges pulsed during RESET and RUN are ignored. start_process held high through rst_n release produces no run.
- rst_n pulsed low mid-RUN -> all outputs return to reset values at once. A new start runs normally and clears the prior finished_mask/cycle_count.
- From DONE, a new start edge with mask 4'b0011 -> goes straight to RESET with cleared stats; NUM_CORES=8 regression repeats scenario 1 with mask 8'hFF.
